// File: rtl/sd_cmd_master_q.sv
`default_nettype none
// ============================================================================
//  Module   : sd_cmd_master_q
//  Purpose  : Queued SD command master. Buffers commands in a circular FIFO,
//             issues them one at a time to the command serialiser, checks
//             responses (timeout / CRC / index), retries on CRC failure and
//             waits out R1b busy before reporting completion.
//  Revision : 1.0 - initial release
// ============================================================================
module sd_cmd_master_q #(
   parameter int QDEPTH    = 4,
   parameter int TO_W      = 16,
   parameter int RETRY_MAX = 2
) (
   input  logic                      CLK_PAD_IO,
   input  logic                      RST_PAD_I,
   input  logic                      cmd_push,
   input  logic [5:0]                cmd_idx,
   input  logic [31:0]               cmd_arg,
   input  logic [1:0]                cmd_rsp,
   input  logic                      cmd_crce,
   input  logic                      cmd_cice,
   input  logic                      abort,
   output logic                      q_full,
   output logic [$clog2(QDEPTH):0]   q_count,
   input  logic [TO_W-1:0]           timeout_i,
   output logic                      ser_req,
   output logic [39:0]               ser_cmd,
   output logic [6:0]                ser_rsp_len,
   input  logic                      ser_ack,
   input  logic                      ser_done,
   input  logic                      ser_crc_ok,
   input  logic [39:0]               ser_rsp,
   input  logic                      dat0_busy,
   output logic [31:0]               resp_o,
   output logic [5:0]                resp_idx_o,
   output logic                      int_cc,
   output logic                      int_err,
   output logic [2:0]                err_code,
   input  logic                      int_rst,
   output logic                      busy_o
);

   localparam int PW    = $clog2(QDEPTH);
   localparam int CW    = PW + 1;
   localparam int EW    = 42;                      // {idx, arg, rsp, crce, cice}
   localparam int ATT_W = $clog2(RETRY_MAX + 2);
   localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(RETRY_MAX);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_BUSYW = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [EW-1:0]     fifo_mem_q [QDEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [5:0]        cur_idx_q, cur_idx_d;
   logic [1:0]        cur_rsp_q, cur_rsp_d;
   logic              cur_crce_q, cur_crce_d, cur_cice_q, cur_cice_d;
   logic [ATT_W-1:0]  att_q, att_d;
   logic [TO_W-1:0]   timer_q, timer_d;
   logic              ser_req_q, ser_req_d;
   logic [39:0]       ser_cmd_q, ser_cmd_d;
   logic [6:0]        ser_rsp_len_q, ser_rsp_len_d;
   logic [31:0]       resp_q, resp_d;
   logic [5:0]        resp_idx_q, resp_idx_d;
   logic              int_cc_q, int_cc_d, int_err_q, int_err_d;
   logic [2:0]        err_code_q, err_code_d;

   logic [EW-1:0]     w_head;
   logic              w_push, w_pop, w_cc_set, w_ierr_set;
   logic [2:0]        w_err_set;
   logic              unused_rsp_bits;

   assign w_head          = fifo_mem_q[rd_ptr_q];
   assign w_push          = cmd_push & ~q_full & ~abort;
   assign unused_rsp_bits = ^ser_rsp[39:38];

   assign q_full      = (count_q == CW'(QDEPTH));
   assign q_count     = count_q;
   assign ser_req     = ser_req_q;
   assign ser_cmd     = ser_cmd_q;
   assign ser_rsp_len = ser_rsp_len_q;
   assign resp_o      = resp_q;
   assign resp_idx_o  = resp_idx_q;
   assign int_cc      = int_cc_q;
   assign int_err     = int_err_q;
   assign err_code    = err_code_q;
   assign busy_o      = (state_q != S_IDLE);

   // Command storage; no reset needed, validity is tracked by the pointers.
   always_ff @(posedge CLK_PAD_IO) begin
      if (w_push) fifo_mem_q[wr_ptr_q] <= {cmd_idx, cmd_arg, cmd_rsp, cmd_crce, cmd_cice};
   end

   // Next-state logic: FIFO bookkeeping, command sequencing and status flags.
   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      cur_idx_d     = cur_idx_q;
      cur_rsp_d     = cur_rsp_q;
      cur_crce_d    = cur_crce_q;
      cur_cice_d    = cur_cice_q;
      att_d         = att_q;
      timer_d       = timer_q;
      ser_req_d     = ser_req_q;
      ser_cmd_d     = ser_cmd_q;
      ser_rsp_len_d = ser_rsp_len_q;
      resp_d        = resp_q;
      resp_idx_d    = resp_idx_q;
      // Clear first so that a set in the same cycle wins.
      int_cc_d      = int_cc_q & ~int_rst;
      int_err_d     = int_err_q & ~int_rst;
      err_code_d    = int_rst ? 3'b000 : err_code_q;
      w_pop         = 1'b0;
      w_err_set     = 3'b000;
      w_cc_set      = 1'b0;
      w_ierr_set    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               w_pop      = 1'b1;
               cur_idx_d  = w_head[41:36];
               cur_rsp_d  = w_head[3:2];
               cur_crce_d = w_head[1];
               cur_cice_d = w_head[0];
               att_d      = '0;
               ser_cmd_d  = {2'b01, w_head[41:36], w_head[35:4]};
               case (w_head[3:2])
                  2'b00:   ser_rsp_len_d = 7'd0;
                  2'b01:   ser_rsp_len_d = 7'd127;
                  default: ser_rsp_len_d = 7'd40;
               endcase
               ser_req_d  = 1'b1;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ser_ack) begin
               ser_req_d = 1'b0;
               timer_d   = '0;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ser_done) begin
               if (cur_rsp_q == 2'b00) begin
                  state_d = S_DONE;
               end else if (cur_crce_q && !ser_crc_ok) begin
                  if (att_q < ATT_MAX) begin
                     att_d     = att_q + ATT_W'(1);
                     ser_req_d = 1'b1;
                     state_d   = S_ISSUE;
                  end else begin
                     w_err_set[1] = 1'b1;
                     state_d      = S_DONE;
                  end
               end else begin
                  // R2 carries no echoed index, so the index check is skipped.
                  if (cur_cice_q && (cur_rsp_q != 2'b01) && (ser_rsp[37:32] != cur_idx_q))
                     w_err_set[2] = 1'b1;
                  resp_d = ser_rsp[31:0];
                  if (cur_rsp_q == 2'b11) begin
                     timer_d = '0;
                     state_d = S_BUSYW;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end else if (timer_q > timeout_i) begin
               w_err_set[0] = 1'b1;
               state_d      = S_DONE;
            end else if (timer_q != '1) begin
               timer_d = timer_q + TO_W'(1);
            end
         end
         S_BUSYW: begin
            if (!dat0_busy) begin
               state_d = S_DONE;
            end else if (timer_q > timeout_i) begin
               w_err_set[0] = 1'b1;
               state_d      = S_DONE;
            end else if (timer_q != '1) begin
               timer_d = timer_q + TO_W'(1);
            end
         end
         S_DONE: begin
            w_cc_set   = 1'b1;
            w_ierr_set = |err_code_q;
            resp_idx_d = cur_idx_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         // Abandon everything silently: no capture, no interrupt, queue flushed.
         state_d       = S_IDLE;
         ser_req_d     = 1'b0;
         ser_cmd_d     = ser_cmd_q;
         ser_rsp_len_d = ser_rsp_len_q;
         resp_d        = resp_q;
         resp_idx_d    = resp_idx_q;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         count_d       = '0;
      end else begin
         if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d    = count_q + (w_push ? CW'(1) : CW'(0)) - (w_pop ? CW'(1) : CW'(0));
         err_code_d = err_code_d | w_err_set;
         int_cc_d   = int_cc_d | w_cc_set;
         int_err_d  = int_err_d | w_ierr_set;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
      if (RST_PAD_I) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         cur_idx_q     <= '0;
         cur_rsp_q     <= '0;
         cur_crce_q    <= 1'b0;
         cur_cice_q    <= 1'b0;
         att_q         <= '0;
         timer_q       <= '0;
         ser_req_q     <= 1'b0;
         ser_cmd_q     <= '0;
         ser_rsp_len_q <= '0;
         resp_q        <= '0;
         resp_idx_q    <= '0;
         int_cc_q      <= 1'b0;
         int_err_q     <= 1'b0;
         err_code_q    <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         cur_idx_q     <= cur_idx_d;
         cur_rsp_q     <= cur_rsp_d;
         cur_crce_q    <= cur_crce_d;
         cur_cice_q    <= cur_cice_d;
         att_q         <= att_d;
         timer_q       <= timer_d;
         ser_req_q     <= ser_req_d;
         ser_cmd_q     <= ser_cmd_d;
         ser_rsp_len_q <= ser_rsp_len_d;
         resp_q        <= resp_d;
         resp_idx_q    <= resp_idx_d;
         int_cc_q      <= int_cc_d;
         int_err_q     <= int_err_d;
         err_code_q    <= err_code_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_master_q.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_cmd_master_q
//  Purpose  : Self-checking bench for sd_cmd_master_q. Expected issues and
//             completions are queued when commands are pushed and compared
//             when the DUT raises ser_req / int_cc.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_master_q;

   localparam int QDEPTH    = 4;
   localparam int TO_W      = 16;
   localparam int RETRY_MAX = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            cmd_push = 1'b0;
   logic [5:0]      cmd_idx = '0;
   logic [31:0]     cmd_arg = '0;
   logic [1:0]      cmd_rsp = '0;
   logic            cmd_crce = 1'b0, cmd_cice = 1'b0, abort = 1'b0;
   logic            q_full;
   logic [2:0]      q_count;
   logic [TO_W-1:0] timeout_i = 16'd1000;
   logic            ser_req;
   logic [39:0]     ser_cmd;
   logic [6:0]      ser_rsp_len;
   logic            ser_ack = 1'b0, ser_done = 1'b0, ser_crc_ok = 1'b0;
   logic [39:0]     ser_rsp = '0;
   logic            dat0_busy = 1'b0;
   logic [31:0]     resp_o;
   logic [5:0]      resp_idx_o;
   logic            int_cc, int_err;
   logic [2:0]      err_code;
   logic            int_rst = 1'b0;
   logic            busy_o;

   sd_cmd_master_q #(.QDEPTH(QDEPTH), .TO_W(TO_W), .RETRY_MAX(RETRY_MAX)) dut (
      .CLK_PAD_IO(clk), .RST_PAD_I(rst),
      .cmd_push(cmd_push), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .cmd_rsp(cmd_rsp),
      .cmd_crce(cmd_crce), .cmd_cice(cmd_cice), .abort(abort),
      .q_full(q_full), .q_count(q_count), .timeout_i(timeout_i),
      .ser_req(ser_req), .ser_cmd(ser_cmd), .ser_rsp_len(ser_rsp_len),
      .ser_ack(ser_ack), .ser_done(ser_done), .ser_crc_ok(ser_crc_ok), .ser_rsp(ser_rsp),
      .dat0_busy(dat0_busy), .resp_o(resp_o), .resp_idx_o(resp_idx_o),
      .int_cc(int_cc), .int_err(int_err), .err_code(err_code), .int_rst(int_rst),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] resp;
      logic [2:0]  err;
   } res_t;

   int          n_total = 0;
   int          n_bad   = 0;
   int          req_rises = 0;
   logic [46:0] exp_issue_q [$];   // {rsp_len, ser_cmd}
   res_t        exp_res_q [$];
   logic [31:0] m_resp = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Issue monitor: every rising ser_req must match the next expected issue.
   logic        req_prev = 1'b0;
   logic [46:0] mon_e;
   always @(negedge clk) begin
      if (ser_req && !req_prev) begin
         req_rises++;
         if (exp_issue_q.size() == 0) begin
            chk("issue_unexpected", 64'd1, 64'd0);
         end else begin
            mon_e = exp_issue_q.pop_front();
            chk("ser_cmd", {24'd0, ser_cmd}, {24'd0, mon_e[39:0]});
            chk("ser_len", {57'd0, ser_rsp_len}, {57'd0, mon_e[46:40]});
         end
      end
      req_prev = ser_req;
   end

   task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rsp,
                           input logic crce, input logic cice, input int n_issue,
                           input bit completes, input logic [31:0] payload, input bit cap,
                           input logic [2:0] err);
      logic [6:0] len;
      res_t r;
      len = (rsp == 2'b00) ? 7'd0 : (rsp == 2'b01) ? 7'd127 : 7'd40;
      cmd_push = 1'b1; cmd_idx = idx; cmd_arg = arg; cmd_rsp = rsp;
      cmd_crce = crce; cmd_cice = cice;
      for (int k = 0; k < n_issue; k++) exp_issue_q.push_back({len, 2'b01, idx, arg});
      if (cap) m_resp = payload;
      if (completes) begin
         r.idx = idx; r.resp = m_resp; r.err = err;
         exp_res_q.push_back(r);
      end
      @(negedge clk);
      cmd_push = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!ser_req && n < 50) begin @(negedge clk); n++; end
      chk(tag, {63'd0, ser_req}, 64'd1);
   endtask

   task automatic do_ack();
      ser_ack = 1'b1;
      @(negedge clk);
      ser_ack = 1'b0;
   endtask

   task automatic do_done(input logic ok, input logic [39:0] rsp);
      ser_done = 1'b1; ser_crc_ok = ok; ser_rsp = rsp;
      @(negedge clk);
      ser_done = 1'b0; ser_crc_ok = 1'b0;
   endtask

   task automatic wait_cc(input string tag);
      res_t r;
      int n = 0;
      while (!int_cc && n < 500) begin @(negedge clk); n++; end
      chk({tag, "_cc"}, {63'd0, int_cc}, 64'd1);
      if (exp_res_q.size() == 0) begin
         chk({tag, "_noexp"}, 64'd1, 64'd0);
      end else begin
         r = exp_res_q.pop_front();
         chk({tag, "_idx"},  {58'd0, resp_idx_o}, {58'd0, r.idx});
         chk({tag, "_resp"}, {32'd0, resp_o},     {32'd0, r.resp});
         chk({tag, "_err"},  {61'd0, err_code},   {61'd0, r.err});
         chk({tag, "_ierr"}, {63'd0, int_err},    {63'd0, |r.err});
      end
      int_rst = 1'b1;
      @(negedge clk);
      int_rst = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl"}, {54'd0, q_full, q_count, ser_req, busy_o, int_cc, int_err, err_code}, 64'd0);
      chk({tag, "_cmd"}, {17'd0, ser_rsp_len, ser_cmd}, 64'd0);
      chk({tag, "_rsp"}, {26'd0, resp_idx_o, resp_o}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
      $fatal(1);
   end

   initial begin
      int base;
      int cnt;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      // CMD0, no response: latency push->req, req drop, done->int_cc.
      push_cmd(6'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1, 1'b1, 32'd0, 1'b0, 3'b000);
      chk("push_qcount", {61'd0, q_count}, 64'd1);
      chk("req_lat_early", {63'd0, ser_req}, 64'd0);
      @(negedge clk);
      chk("req_lat", {63'd0, ser_req}, 64'd1);
      chk("pop_qcount", {61'd0, q_count}, 64'd0);
      chk("busy_on", {63'd0, busy_o}, 64'd1);
      repeat (2) @(negedge clk);
      do_ack();
      chk("req_drop", {63'd0, ser_req}, 64'd0);
      repeat (6) @(negedge clk);
      do_done(1'b1, 40'd0);
      chk("cc_lat_early", {63'd0, int_cc}, 64'd0);
      @(negedge clk);
      chk("cc_lat", {63'd0, int_cc}, 64'd1);
      wait_cc("cmd0");

      // CMD17 with CRC and index check, good response.
      push_cmd(6'd17, 32'h0000_0200, 2'b10, 1'b1, 1'b1, 1, 1'b1, 32'h0000_0900, 1'b1, 3'b000);
      wait_req("cmd17_req");
      do_ack();
      repeat (3) @(negedge clk);
      do_done(1'b1, {2'b00, 6'd17, 32'h0000_0900});
      wait_cc("cmd17");

      // Three bad CRCs exhaust the retries.
      push_cmd(6'd18, 32'h1234, 2'b10, 1'b1, 1'b0, 3, 1'b1, 32'd0, 1'b0, 3'b010);
      base = req_rises;
      for (int i = 0; i < 3; i++) begin
         wait_req("rty_req");
         do_ack();
         @(negedge clk);
         do_done(1'b0, {2'b00, 6'd18, 32'hdead});
         if (i < 2) chk("rty_lat", {63'd0, ser_req}, 64'd1);
      end
      wait_cc("rty_fail");
      chk("rty_count", 64'(req_rises - base), 64'd3);

      // Bad CRC then good on retry.
      push_cmd(6'd18, 32'h1234, 2'b10, 1'b1, 1'b0, 2, 1'b1, 32'h0000_0abc, 1'b1, 3'b000);
      wait_req("rty2_req");
      do_ack();
      do_done(1'b0, {2'b00, 6'd18, 32'hbad0});
      wait_req("rty2_req2");
      do_ack();
      do_done(1'b1, {2'b00, 6'd18, 32'h0000_0abc});
      wait_cc("rty_ok");

      // Index mismatch on a 48-bit response.
      push_cmd(6'd13, 32'd0, 2'b10, 1'b0, 1'b1, 1, 1'b1, 32'h55, 1'b1, 3'b100);
      wait_req("idx_req");
      do_ack();
      do_done(1'b1, {2'b00, 6'd12, 32'h55});
      wait_cc("idx_err");

      // R2 ignores the index field.
      push_cmd(6'd2, 32'd0, 2'b01, 1'b0, 1'b1, 1, 1'b1, 32'h77, 1'b1, 3'b000);
      wait_req("r2_req");
      do_ack();
      do_done(1'b1, {2'b00, 6'd63, 32'h77});
      wait_cc("r2");

      // Response timeout at timer 21 with timeout_i = 20.
      timeout_i = 16'd20;
      push_cmd(6'd5, 32'd0, 2'b10, 1'b0, 1'b0, 1, 1'b1, 32'd0, 1'b0, 3'b001);
      wait_req("to_req");
      do_ack();
      cnt = 1;
      while (!err_code[0] && cnt < 100) begin @(negedge clk); cnt++; end
      chk("to_latency", 64'(cnt), 64'd23);
      wait_cc("timeout");

      // R1b with DAT0 busy for 50 cycles, timeout 100.
      timeout_i = 16'd100;
      push_cmd(6'd38, 32'h5, 2'b11, 1'b1, 1'b1, 1, 1'b1, 32'h0000_900d, 1'b1, 3'b000);
      wait_req("r1b_req");
      do_ack();
      dat0_busy = 1'b1;
      do_done(1'b1, {2'b00, 6'd38, 32'h0000_900d});
      repeat (50) @(negedge clk);
      chk("r1b_hold", {63'd0, int_cc}, 64'd0);
      dat0_busy = 1'b0;
      wait_cc("r1b");

      // Fill the queue behind a stalled command; 6th push is dropped.
      for (int i = 0; i < 5; i++)
         push_cmd(6'(20 + i), 32'(i), 2'b00, 1'b0, 1'b0, 1, 1'b1, 32'd0, 1'b0, 3'b000);
      chk("q_full", {63'd0, q_full}, 64'd1);
      chk("q_count4", {61'd0, q_count}, 64'd4);
      push_cmd(6'd26, 32'd9, 2'b00, 1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0, 3'b000);
      chk("q_drop", {61'd0, q_count}, 64'd4);
      for (int i = 0; i < 5; i++) begin
         wait_req("q_req");
         do_ack();
         do_done(1'b1, 40'd0);
         wait_cc("q_cmd");
         if (i == 0) chk("b2b_req", {63'd0, ser_req}, 64'd1);
      end

      // Abort during WAIT with two queued; simultaneous push is dropped.
      push_cmd(6'd40, 32'd1, 2'b10, 1'b0, 1'b0, 1, 1'b0, 32'd0, 1'b0, 3'b000);
      push_cmd(6'd41, 32'd2, 2'b10, 1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0, 3'b000);
      push_cmd(6'd42, 32'd3, 2'b10, 1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0, 3'b000);
      wait_req("ab_req");
      do_ack();
      chk("ab_qcount", {61'd0, q_count}, 64'd2);
      abort = 1'b1; cmd_push = 1'b1; cmd_idx = 6'd43;
      @(negedge clk);
      abort = 1'b0; cmd_push = 1'b0;
      chk("ab_state", {59'd0, busy_o, ser_req, int_cc, q_count}, 64'd0);
      repeat (5) @(negedge clk);
      chk("ab_idle", {60'd0, ser_req, q_count}, 64'd0);

      // Reset in the middle of WAIT.
      push_cmd(6'd44, 32'd4, 2'b10, 1'b0, 1'b0, 1, 1'b0, 32'd0, 1'b0, 3'b000);
      wait_req("rst_req");
      do_ack();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("issue_left", 64'(exp_issue_q.size()), 64'd0);
      chk("result_left", 64'(exp_res_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sd_cmd_master_q.md
# sd_cmd_master_q

Queued, parametrised SD command master for the SD host controller's command path. Accepts SD commands from the register/DMA side into a depth-configurable FIFO, issues them one at a time to the command serialiser, and collects each response. Adds per-command timeout, response CRC/index checking, automatic retry on CRC failure and R1b busy-wait before completion. Runs entirely on CLK_PAD_IO; the serialiser handshake is synchronised externally.

## Interface
Parameters:
- QDEPTH, 4, command FIFO depth (power of two, ≥2)
- TO_W, 16, width of timeout and busy counters
- RETRY_MAX, 2, extra attempts after a response CRC error (0 = no retry)

Ports:
- CLK_PAD_IO  in  1  system clock
- RST_PAD_I  in  1  asynchronous, active-high reset
- cmd_push  in  1  enqueue command (ignored when q_full)
- cmd_idx  in  6  command index
- cmd_arg  in  32  command argument
- cmd_rsp  in  2  00 none, 01 R2 (136-bit), 10 48-bit, 11 48-bit + busy (R1b)
- cmd_crce, cmd_cice  in  1 each  enable CRC / index check for this command
- abort  in  1  flush queue, abandon current command
- q_full  out  1  FIFO full
- q_count  out  clog2(QDEPTH)+1  entries queued (excl. in-flight)
- timeout_i  in  TO_W  response timeout in cycles
- ser_req  out  1  start request to serialiser (level)
- ser_cmd  out  40  {2'b01, idx, arg}
- ser_rsp_len  out  7  0, 40 (7'd40) or 127
- ser_ack  in  1  serialiser accepted request (1-cycle pulse)
- ser_done  in  1  response received / no-response command sent (pulse)
- ser_crc_ok  in  1  valid with ser_done
- ser_rsp  in  40  received response bits {..., idx[37:32], payload[31:0]}
- dat0_busy  in  1  DAT0 held low by card
- resp_o  out  32  last response payload
- resp_idx_o  out  6  index of last completed command
- int_cc  out  1  command complete (sticky)
- int_err  out  1  error (sticky)
- err_code  out  3  bit0 timeout, bit1 CRC, bit2 index (sticky)
- int_rst  in  1  clear int_cc, int_err, err_code
- busy_o  out  1  FSM not in IDLE

## Operation
- FIFO: circular, write on cmd_push & ~q_full, read on IDLE→ISSUE. Push and pop in same cycle: count unchanged. Push when full: dropped, no flag change.
- States: IDLE, ISSUE, WAIT, BUSYW, DONE.
- IDLE: if q_count≠0 pop head into current-command register, clear attempt counter, → ISSUE.
- ISSUE: ser_req=1, ser_cmd/ser_rsp_len from current command; on ser_ack drop ser_req, clear timer, → WAIT.
- WAIT: timer increments each cycle. On ser_done:
  - cmd_rsp=00: → DONE.
  - crce & ~ser_crc_ok: if attempts<RETRY_MAX, attempts+1, → ISSUE; else set err_code[1], → DONE.
  - cice & ser_rsp[37:32]≠cmd_idx (not checked for R2): set err_code[2].
  - capture resp_o=ser_rsp[31:0] (R2: ser_rsp[31:0] as supplied), → BUSYW if cmd_rsp=11 else DONE.
  - timer>timeout_i before ser_done: set err_code[0], → DONE.
- BUSYW: wait for dat0_busy=0; shares timer (cleared on entry); timeout sets err_code[0], → DONE.
- DONE: int_cc=1, resp_idx_o=cmd_idx, int_err|=|err_code; → IDLE (1 cycle).
- abort: any state → IDLE next cycle, ser_req=0, FIFO emptied, no interrupt set. abort with cmd_push same cycle: push dropped.
- int_rst same cycle as set: set wins.
- Timer saturates at all-ones; no wrap.

## Timing
- Reset: all outputs 0, FIFO empty, state IDLE, q_count=0.
- Push to ser_req rise (empty queue, idle): 2 cycles (push cycle +1 write, +1 ISSUE).
- ser_req deasserts cycle after ser_ack sampled.
- ser_done to int_cc: 2 cycles (WAIT→DONE, DONE registers int_cc) for non-busy commands.
- Retry: ser_req reasserted 1 cycle after failing ser_done.
- Back-to-back queued commands: ser_req for next command 2 cycles after previous DONE.
- ser_ack/ser_done ignored outside ISSUE/WAIT respectively.

## Test plan
- Push CMD0 (rsp 00), ack at +3, done at +10 → int_cc=1, resp_idx_o=0, err_code=0, resp_o unchanged.
- Push CMD17 arg 0x0000_0200, rsp 10, crce, ser_rsp idx 17 payload 0x0000_0900, crc ok → resp_o=0x0000_0900, int_cc=1, int_err=0.
- RETRY_MAX=2, three CRC-bad responses → exactly 3 ser_req assertions, err_code=3'b010, int_err=1; second good on retry → err_code=0.
- timeout_i=20, no ser_done → err_code[0]=1 at timer 21; R1b with dat0_busy held 50 cycles, timeout 100 → int_cc after busy release, no error.
- Push 5 commands with QDEPTH=4 while idle-blocked (ser_ack held 0) → q_full after 4 queued +1 in flight, 6th dropped; order of ser_cmd indices preserved.
- abort during WAIT with 2 queued → IDLE, q_count=0, ser_req=0, int_cc unchanged; reset mid-WAIT → all outputs 0.
